dlx_mem_stage: RTL

- DLX MEM stage, between the EX/MEM pipeline registers (upstream) and mem_wb_regs (downstream).
- Issues load/store requests to a variable-latency data memory over a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Aligns and extends load data into lmd.
- Passes the ALU result, rd and control bits through to MEM/WB.
- Detects misaligned accesses.

---
 rtl/dlx_pkg.sv | 22 ++
 rtl/dlx_mem_align.sv | 50 +++++
 rtl/dlx_mem_stage.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dlx_pkg.sv
// Shared encodings for the DLX MEM stage: access sizes, MEM FSM states and
// a misalignment helper.
package dlx_pkg;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;  // 2'b11 is handled as a word

  typedef enum logic {
    IDLE,
    WAIT
  } mem_state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_SIZE_BYTE: is_misaligned = 1'b0;
      MEM_SIZE_HALF: is_misaligned = addr_lo[0];
      default:       is_misaligned = |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/dlx_mem_align.sv
// Combinational byte-lane steering: store data replication and byte enables,
// load lane extraction with sign/zero extension.
module dlx_mem_align
  import dlx_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [1:0]  lane;
  logic        upper_half;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Big-endian puts address offset 0 in the most significant lane.
  assign lane       = BIG_ENDIAN ? ~addr_lo : addr_lo;
  assign upper_half = BIG_ENDIAN ? ~addr_lo[1] : addr_lo[1];
  assign byte_val   = rdata[{lane, 3'b000} +: 8];
  assign half_val   = upper_half ? rdata[31:16] : rdata[15:0];

  // NOTE: every output gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    wdata     = store_data;
    be        = 4'b1111;
    load_data = rdata;
    case (size)
      MEM_SIZE_BYTE: begin
        wdata     = {4{store_data[7:0]}};
        be        = 4'b0001 << lane;
        load_data = {{24{~load_unsigned & byte_val[7]}}, byte_val};
      end
      MEM_SIZE_HALF: begin
        wdata     = {2{store_data[15:0]}};
        be        = upper_half ? 4'b1100 : 4'b0011;
        load_data = {{16{~load_unsigned & half_val[15]}}, half_val};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dlx_mem_stage.sv
// DLX MEM stage: req/ack data-memory access with pipeline stall, load
// alignment and misalignment detection. Optional wait timeout: DLX_MEM_TIMEOUT_EN.
module dlx_mem_stage
  import dlx_pkg::*;
#(
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] aluoutput_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_size_in,
  input  logic        load_unsigned_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall_out,
  output logic [31:0] lmd_out,
  output logic [31:0] aluoutput_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        misalign_err,
  output logic        mem_timeout_err
);

  mem_state_t  state, state_next;
  logic        mem_op, is_load, misaligned, issue, ack_done, timeout_hit;
  logic [31:0] align_wdata, align_load;
  logic [3:0]  align_be;

  assign mem_op     = mem_read_in | mem_write_in;
  assign is_load    = mem_read_in & ~mem_write_in;
  assign misaligned = mem_op & is_misaligned(mem_size_in, aluoutput_in[1:0]);
  assign issue      = (state == IDLE) & mem_op & ~misaligned;
  assign ack_done   = (state == WAIT) & dmem_ack;

  dlx_mem_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .addr_lo       (aluoutput_in[1:0]),
    .size          (mem_size_in),
    .load_unsigned (load_unsigned_in),
    .store_data    (store_data_in),
    .rdata         (dmem_rdata),
    .wdata         (align_wdata),
    .be            (align_be),
    .load_data     (align_load)
  );

`ifdef DLX_MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == WAIT) & ~dmem_ack &
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset || state != WAIT || dmem_ack || timeout_hit) wait_cnt <= '0;
    else                                                     wait_cnt <= wait_cnt + 1'b1;
  end
`else
  localparam int unsigned timeout_cycles_unused = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (issue) state_next = WAIT;
      WAIT: if (ack_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= '0;
    end else begin
      state <= state_next;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= mem_write_in;
        dmem_addr  <= {aluoutput_in[31:2], 2'b00};
        dmem_wdata <= align_wdata;
        dmem_be    <= align_be;
      end else if (ack_done || timeout_hit) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
      end
    end
  end

  // Pipeline-facing outputs; all held at zero while reset is asserted.
  always_comb begin
    stall_out       = 1'b0;
    lmd_out         = '0;
    aluoutput_out   = '0;
    rd_out          = '0;
    reg_write_out   = 1'b0;
    mem_to_reg_out  = 1'b0;
    misalign_err    = 1'b0;
    mem_timeout_err = 1'b0;
    if (reset) begin
      aluoutput_out  = aluoutput_in;
      rd_out         = rd_in;
      mem_to_reg_out = mem_to_reg_in;
      case (state)
        IDLE: begin
          if (misaligned)  misalign_err  = 1'b1;
          else if (mem_op) stall_out     = 1'b1;
          else             reg_write_out = reg_write_in;
        end
        WAIT: begin
          if (dmem_ack) begin
            reg_write_out = reg_write_in;
            lmd_out       = is_load ? align_load : 32'h0;
          end else if (timeout_hit) begin
            mem_timeout_err = 1'b1;
          end else begin
            stall_out = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
